// File: rtl/lazy_job_scheduler_pkg.sv
// Shared widths, context encoding and sequence entry layout
// for the lazy match job scheduler.
package lazy_job_scheduler_pkg;

    localparam int JOB_LEN         = 64;
    localparam int JOB_LEN_LOG2    = 6;
    localparam int LAZY_LEN        = 4;
    localparam int SEQ_LL_BITS     = 8;
    localparam int SEQ_ML_BITS     = 8;
    localparam int SEQ_OFFSET_BITS = 16;

    localparam int NUM_CTX  = 4;
    localparam int CTX_BITS = $clog2(NUM_CTX);

    typedef enum logic [1:0] {
        CTX_FREE     = 2'd0,
        CTX_READY    = 2'd1,
        CTX_INFLIGHT = 2'd2
    } ctx_state_e;

    typedef struct packed {
        logic [CTX_BITS-1:0]        ctx;
        logic [SEQ_LL_BITS-1:0]     ll;
        logic [SEQ_ML_BITS-1:0]     ml;
        logic [SEQ_OFFSET_BITS-1:0] offset;
        logic                       eoj;
        logic [SEQ_ML_BITS-1:0]     overlap;
        logic                       delim;
    } seq_entry_t;

    localparam int SEQ_W = $bits(seq_entry_t);

    function automatic logic [CTX_BITS-1:0] ctx_next(
        input logic [CTX_BITS-1:0] c
    );
        return (int'(c) == NUM_CTX - 1) ? '0 : c + 1'b1;
    endfunction

endpackage

// File: rtl/lazy_job_scheduler_sync_fifo.sv
// Small synchronous FIFO with occupancy count; used for
// the in-order tag queue and the output sequence queue.
module lazy_job_scheduler_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    cnt_q;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign empty    = (cnt_q == '0);
    assign count    = cnt_q;

endmodule

// File: rtl/lazy_job_scheduler.sv
// Interleaves up to NUM_CTX lazy-match jobs over one
// fixed-latency match pipeline and collects their sequences.
module lazy_job_scheduler
    import lazy_job_scheduler_pkg::*;
#(
    parameter int MAX_INFLIGHT   = 8,
    parameter int SEQ_FIFO_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_job_valid,
    input  logic                       i_job_delim,
    output logic                       o_job_ready,
    output logic [CTX_BITS-1:0]        o_job_ctx,
    output logic                       o_release_valid,
    output logic [CTX_BITS-1:0]        o_release_ctx,
    output logic                       o_req_valid,
    input  logic                       i_req_ready,
    output logic [CTX_BITS-1:0]        o_req_ctx,
    output logic [JOB_LEN_LOG2-1:0]    o_req_seq_head_ptr,
    output logic [JOB_LEN_LOG2-1:0]    o_req_match_head_ptr,
    output logic                       o_req_delim,
    input  logic                       i_summary_done,
    input  logic [SEQ_LL_BITS-1:0]     i_summary_ll,
    input  logic [SEQ_ML_BITS-1:0]     i_summary_ml,
    input  logic [SEQ_OFFSET_BITS-1:0] i_summary_offset,
    input  logic [SEQ_ML_BITS-1:0]     i_summary_overlap_len,
    input  logic                       i_summary_eoj,
    input  logic                       i_move_to_next_job,
    input  logic [JOB_LEN_LOG2-1:0]    i_move_forward,
    output logic                       o_seq_valid,
    input  logic                       i_seq_ready,
    output logic [CTX_BITS-1:0]        o_seq_ctx,
    output logic [SEQ_LL_BITS-1:0]     o_seq_ll,
    output logic [SEQ_ML_BITS-1:0]     o_seq_ml,
    output logic [SEQ_OFFSET_BITS-1:0] o_seq_offset,
    output logic                       o_seq_eoj,
    output logic [SEQ_ML_BITS-1:0]     o_seq_overlap_len,
    output logic                       o_seq_delim,
    output logic                       o_err
);

    localparam int TCW = $clog2(MAX_INFLIGHT + 1);
    localparam int SCW = $clog2(SEQ_FIFO_DEPTH + 1);
    localparam int CRW = 16;
    localparam int HW  = JOB_LEN_LOG2;

    ctx_state_e          state_q      [NUM_CTX];
    ctx_state_e          state_d      [NUM_CTX];
    logic [HW-1:0]       seq_head_q   [NUM_CTX];
    logic [HW-1:0]       seq_head_d   [NUM_CTX];
    logic [HW-1:0]       match_head_q [NUM_CTX];
    logic [HW-1:0]       match_head_d [NUM_CTX];
    logic                delim_q      [NUM_CTX];
    logic                delim_d      [NUM_CTX];

    logic                rst_done_q;
    logic                err_q;
    logic                rel_valid_q;
    logic [CTX_BITS-1:0] rel_ctx_q;
    logic [CTX_BITS-1:0] rr_q;
    logic                req_valid_q;
    logic [CTX_BITS-1:0] req_ctx_q;
    logic [HW-1:0]       req_sh_q;
    logic [HW-1:0]       req_mh_q;
    logic                req_delim_q;

    logic                any_free;
    logic [CTX_BITS-1:0] free_ctx;
    logic                accept;
    logic                hs;
    logic                wb;
    logic                tag_empty;
    logic [TCW-1:0]      tag_cnt;
    logic [CTX_BITS-1:0] wb_ctx;
    logic                seq_empty;
    logic                seq_pop;
    logic [SCW-1:0]      seq_cnt;
    seq_entry_t          seq_out;

    logic [HW-1:0]       wb_cur_sh;
    logic [HW-1:0]       wb_cur_mh;
    logic                wb_tail;
    logic                wb_noml;
    logic [HW:0]         wb_tail_ll;
    logic                wb_c1;
    logic                wb_c2;
    logic                wb_c3;
    logic                wb_push;
    logic                wb_rel;
    seq_entry_t          wb_entry;
    logic [HW-1:0]       wb_sh;
    logic [HW-1:0]       wb_mh;

    logic [NUM_CTX-1:0]  cand;
    logic [CTX_BITS-1:0] rr_base;
    logic                sel_found;
    logic [CTX_BITS-1:0] sel_ctx;
    logic [CRW-1:0]      infl_nx;
    logic [CRW-1:0]      seqc_nx;
    logic                credit_ok;
    logic                load;

    // lowest-index free context for the loader
    always_comb begin
        any_free = 1'b0;
        free_ctx = '0;
        for (int i = NUM_CTX - 1; i >= 0; i--) begin
            if (state_q[i] == CTX_FREE) begin
                any_free = 1'b1;
                free_ctx = CTX_BITS'(i);
            end
        end
    end

    assign accept  = i_job_valid && rst_done_q && any_free;
    assign hs      = req_valid_q && i_req_ready;
    assign wb      = i_summary_done && !tag_empty;
    assign seq_pop = i_seq_ready && !seq_empty;

    lazy_job_scheduler_sync_fifo #(
        .WIDTH (CTX_BITS),
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (hs),
        .push_data (req_ctx_q),
        .pop       (wb),
        .pop_data  (wb_ctx),
        .empty     (tag_empty),
        .count     (tag_cnt)
    );

    lazy_job_scheduler_sync_fifo #(
        .WIDTH (SEQ_W),
        .DEPTH (SEQ_FIFO_DEPTH)
    ) u_seq_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wb_push),
        .push_data (wb_entry),
        .pop       (seq_pop),
        .pop_data  (seq_out),
        .empty     (seq_empty),
        .count     (seq_cnt)
    );

    assign wb_cur_sh  = seq_head_q[wb_ctx];
    assign wb_cur_mh  = match_head_q[wb_ctx];
    assign wb_tail    = ({1'b0, wb_cur_mh} + (HW+1)'(LAZY_LEN))
                        >= (HW+1)'(JOB_LEN);
    assign wb_noml    = (i_summary_ml == '0);
    assign wb_tail_ll = (HW+1)'(JOB_LEN) - {1'b0, wb_cur_sh};
    assign wb_c1      = i_move_to_next_job;
    assign wb_c2      = !i_move_to_next_job && wb_noml && wb_tail;
    assign wb_c3      = !i_move_to_next_job && wb_noml && !wb_tail;

    // decode a returning summary into a sequence push and head update
    always_comb begin
        wb_push        = 1'b0;
        wb_rel         = 1'b0;
        wb_entry       = '0;
        wb_entry.ctx   = wb_ctx;
        wb_entry.delim = delim_q[wb_ctx];
        wb_sh          = wb_cur_sh;
        wb_mh          = wb_cur_mh;
        if (wb) begin
            unique case (1'b1)
                wb_c1: begin
                    wb_push          = 1'b1;
                    wb_rel           = 1'b1;
                    wb_entry.ll      = i_summary_ll;
                    wb_entry.ml      = i_summary_ml;
                    wb_entry.offset  = i_summary_offset;
                    wb_entry.eoj     = i_summary_eoj || i_move_to_next_job;
                    wb_entry.overlap = i_summary_overlap_len;
                end
                wb_c2: begin
                    wb_push      = 1'b1;
                    wb_rel       = 1'b1;
                    wb_entry.ll  = SEQ_LL_BITS'(wb_tail_ll);
                    wb_entry.eoj = 1'b1;
                end
                wb_c3: begin
                    wb_mh = wb_cur_mh + HW'(LAZY_LEN);
                end
                default: begin
                    wb_push          = 1'b1;
                    wb_entry.ll      = i_summary_ll;
                    wb_entry.ml      = i_summary_ml;
                    wb_entry.offset  = i_summary_offset;
                    wb_entry.overlap = i_summary_overlap_len;
                    wb_sh            = wb_cur_sh + i_move_forward;
                    wb_mh            = wb_cur_sh + i_move_forward;
                end
            endcase
        end
    end

    // round-robin pick among ready contexts not already on the bus
    always_comb begin
        rr_base   = hs ? ctx_next(req_ctx_q) : rr_q;
        sel_found = 1'b0;
        sel_ctx   = '0;
        for (int i = 0; i < NUM_CTX; i++) begin
            cand[i] = (state_q[i] == CTX_READY)
                      && !(req_valid_q && req_ctx_q == CTX_BITS'(i));
        end
        for (int k = NUM_CTX - 1; k >= 0; k--) begin
            if (cand[(int'(rr_base) + k) % NUM_CTX]) begin
                sel_found = 1'b1;
                sel_ctx   = CTX_BITS'((int'(rr_base) + k) % NUM_CTX);
            end
        end
    end

    assign infl_nx   = CRW'(tag_cnt) + CRW'(hs) - CRW'(wb);
    assign seqc_nx   = CRW'(seq_cnt) + CRW'(wb_push) - CRW'(seq_pop);
    assign credit_ok = (infl_nx < CRW'(MAX_INFLIGHT))
                       && (seqc_nx + infl_nx < CRW'(SEQ_FIFO_DEPTH));
    assign load      = (!req_valid_q || hs) && sel_found && credit_ok;

    // per-context next state: accept, issue and writeback
    always_comb begin
        for (int i = 0; i < NUM_CTX; i++) begin
            state_d[i]      = state_q[i];
            seq_head_d[i]   = seq_head_q[i];
            match_head_d[i] = match_head_q[i];
            delim_d[i]      = delim_q[i];
            if (accept && free_ctx == CTX_BITS'(i)) begin
                state_d[i]      = CTX_READY;
                seq_head_d[i]   = '0;
                match_head_d[i] = '0;
                delim_d[i]      = i_job_delim;
            end
            if (hs && req_ctx_q == CTX_BITS'(i)) begin
                state_d[i] = CTX_INFLIGHT;
            end
            if (wb && wb_ctx == CTX_BITS'(i)) begin
                state_d[i]      = wb_rel ? CTX_FREE : CTX_READY;
                seq_head_d[i]   = wb_sh;
                match_head_d[i] = wb_mh;
            end
        end
    end

    // per-context state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CTX; i++) begin
                state_q[i]      <= CTX_FREE;
                seq_head_q[i]   <= '0;
                match_head_q[i] <= '0;
                delim_q[i]      <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_CTX; i++) begin
                state_q[i]      <= state_d[i];
                seq_head_q[i]   <= seq_head_d[i];
                match_head_q[i] <= match_head_d[i];
                delim_q[i]      <= delim_d[i];
            end
        end
    end

    // registered request, held until the engine takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_valid_q <= 1'b0;
            req_ctx_q   <= '0;
            req_sh_q    <= '0;
            req_mh_q    <= '0;
            req_delim_q <= 1'b0;
            rr_q        <= '0;
        end else begin
            if (load) begin
                req_valid_q <= 1'b1;
                req_ctx_q   <= sel_ctx;
                req_sh_q    <= seq_head_q[sel_ctx];
                req_mh_q    <= match_head_q[sel_ctx];
                req_delim_q <= delim_q[sel_ctx];
            end else if (hs) begin
                req_valid_q <= 1'b0;
            end
            if (hs) rr_q <= rr_base;
        end
    end

    // release pulse, sticky error and post-reset ready gate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done_q  <= 1'b0;
            err_q       <= 1'b0;
            rel_valid_q <= 1'b0;
            rel_ctx_q   <= '0;
        end else begin
            rst_done_q  <= 1'b1;
            err_q       <= err_q || (i_summary_done && tag_empty);
            rel_valid_q <= wb_rel;
            if (wb_rel) rel_ctx_q <= wb_ctx;
        end
    end

    assign o_job_ready          = rst_done_q && any_free;
    assign o_job_ctx            = free_ctx;
    assign o_release_valid      = rel_valid_q;
    assign o_release_ctx        = rel_ctx_q;
    assign o_req_valid          = req_valid_q;
    assign o_req_ctx            = req_ctx_q;
    assign o_req_seq_head_ptr   = req_sh_q;
    assign o_req_match_head_ptr = req_mh_q;
    assign o_req_delim          = req_delim_q;
    assign o_seq_valid          = !seq_empty;
    assign o_seq_ctx            = seq_out.ctx;
    assign o_seq_ll             = seq_out.ll;
    assign o_seq_ml             = seq_out.ml;
    assign o_seq_offset         = seq_out.offset;
    assign o_seq_eoj            = seq_out.eoj;
    assign o_seq_overlap_len    = seq_out.overlap;
    assign o_seq_delim          = seq_out.delim;
    assign o_err                = err_q;

endmodule

// File: tb/tb_lazy_job_scheduler.sv
// Directed bench for lazy_job_scheduler: the bench plays
// job loader, match engine and sequence writer.
module tb_lazy_job_scheduler;
    import lazy_job_scheduler_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       i_job_valid;
    logic                       i_job_delim;
    logic                       o_job_ready;
    logic [CTX_BITS-1:0]        o_job_ctx;
    logic                       o_release_valid;
    logic [CTX_BITS-1:0]        o_release_ctx;
    logic                       o_req_valid;
    logic                       i_req_ready;
    logic [CTX_BITS-1:0]        o_req_ctx;
    logic [JOB_LEN_LOG2-1:0]    o_req_seq_head_ptr;
    logic [JOB_LEN_LOG2-1:0]    o_req_match_head_ptr;
    logic                       o_req_delim;
    logic                       i_summary_done;
    logic [SEQ_LL_BITS-1:0]     i_summary_ll;
    logic [SEQ_ML_BITS-1:0]     i_summary_ml;
    logic [SEQ_OFFSET_BITS-1:0] i_summary_offset;
    logic [SEQ_ML_BITS-1:0]     i_summary_overlap_len;
    logic                       i_summary_eoj;
    logic                       i_move_to_next_job;
    logic [JOB_LEN_LOG2-1:0]    i_move_forward;
    logic                       o_seq_valid;
    logic                       i_seq_ready;
    logic [CTX_BITS-1:0]        o_seq_ctx;
    logic [SEQ_LL_BITS-1:0]     o_seq_ll;
    logic [SEQ_ML_BITS-1:0]     o_seq_ml;
    logic [SEQ_OFFSET_BITS-1:0] o_seq_offset;
    logic                       o_seq_eoj;
    logic [SEQ_ML_BITS-1:0]     o_seq_overlap_len;
    logic                       o_seq_delim;
    logic                       o_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lazy_job_scheduler #(
        .MAX_INFLIGHT   (4),
        .SEQ_FIFO_DEPTH (4)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .i_job_valid          (i_job_valid),
        .i_job_delim          (i_job_delim),
        .o_job_ready          (o_job_ready),
        .o_job_ctx            (o_job_ctx),
        .o_release_valid      (o_release_valid),
        .o_release_ctx        (o_release_ctx),
        .o_req_valid          (o_req_valid),
        .i_req_ready          (i_req_ready),
        .o_req_ctx            (o_req_ctx),
        .o_req_seq_head_ptr   (o_req_seq_head_ptr),
        .o_req_match_head_ptr (o_req_match_head_ptr),
        .o_req_delim          (o_req_delim),
        .i_summary_done       (i_summary_done),
        .i_summary_ll         (i_summary_ll),
        .i_summary_ml         (i_summary_ml),
        .i_summary_offset     (i_summary_offset),
        .i_summary_overlap_len(i_summary_overlap_len),
        .i_summary_eoj        (i_summary_eoj),
        .i_move_to_next_job   (i_move_to_next_job),
        .i_move_forward       (i_move_forward),
        .o_seq_valid          (o_seq_valid),
        .i_seq_ready          (i_seq_ready),
        .o_seq_ctx            (o_seq_ctx),
        .o_seq_ll             (o_seq_ll),
        .o_seq_ml             (o_seq_ml),
        .o_seq_offset         (o_seq_offset),
        .o_seq_eoj            (o_seq_eoj),
        .o_seq_overlap_len    (o_seq_overlap_len),
        .o_seq_delim          (o_seq_delim),
        .o_err                (o_err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic accept_job(input string tag, input logic delim,
                              input int exp_ctx);
        check({tag, "_ready"}, 32'(o_job_ready), 1);
        check({tag, "_ctx"}, 32'(o_job_ctx), exp_ctx);
        i_job_valid = 1'b1;
        i_job_delim = delim;
        @(negedge clk);
        i_job_valid = 1'b0;
        i_job_delim = 1'b0;
    endtask

    task automatic take_req(input string tag, input int exp_ctx,
                            input int exp_sh, input int exp_mh,
                            input int exp_delim);
        int n = 0;
        while (!o_req_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(o_req_valid), 1);
        check({tag, "_ctx"}, 32'(o_req_ctx), exp_ctx);
        check({tag, "_sh"}, 32'(o_req_seq_head_ptr), exp_sh);
        check({tag, "_mh"}, 32'(o_req_match_head_ptr), exp_mh);
        check({tag, "_delim"}, 32'(o_req_delim), exp_delim);
        i_req_ready = 1'b1;
        @(negedge clk);
        i_req_ready = 1'b0;
    endtask

    task automatic summary(input int ll, input int ml, input int off,
                           input int ovl, input int mf,
                           input logic mtn, input logic eoj);
        i_summary_ll          = SEQ_LL_BITS'(ll);
        i_summary_ml          = SEQ_ML_BITS'(ml);
        i_summary_offset      = SEQ_OFFSET_BITS'(off);
        i_summary_overlap_len = SEQ_ML_BITS'(ovl);
        i_move_forward        = JOB_LEN_LOG2'(mf);
        i_move_to_next_job    = mtn;
        i_summary_eoj         = eoj;
        i_summary_done        = 1'b1;
        @(negedge clk);
        i_summary_done        = 1'b0;
        i_summary_ll          = '0;
        i_summary_ml          = '0;
        i_summary_offset      = '0;
        i_summary_overlap_len = '0;
        i_move_forward        = '0;
        i_move_to_next_job    = 1'b0;
        i_summary_eoj         = 1'b0;
    endtask

    task automatic pop_seq(input string tag, input int ctx, input int ll,
                           input int ml, input int off, input int eoj,
                           input int ovl, input int delim);
        int n = 0;
        while (!o_seq_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(o_seq_valid), 1);
        check({tag, "_ctx"}, 32'(o_seq_ctx), ctx);
        check({tag, "_ll"}, 32'(o_seq_ll), ll);
        check({tag, "_ml"}, 32'(o_seq_ml), ml);
        check({tag, "_off"}, 32'(o_seq_offset), off);
        check({tag, "_eoj"}, 32'(o_seq_eoj), eoj);
        check({tag, "_ovl"}, 32'(o_seq_overlap_len), ovl);
        check({tag, "_delim"}, 32'(o_seq_delim), delim);
        i_seq_ready = 1'b1;
        @(negedge clk);
        i_seq_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n                 = 1'b0;
        i_job_valid           = 1'b0;
        i_job_delim           = 1'b0;
        i_req_ready           = 1'b0;
        i_summary_done        = 1'b0;
        i_summary_ll          = '0;
        i_summary_ml          = '0;
        i_summary_offset      = '0;
        i_summary_overlap_len = '0;
        i_summary_eoj         = 1'b0;
        i_move_to_next_job    = 1'b0;
        i_move_forward        = '0;
        i_seq_ready           = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_job_ready", 32'(o_job_ready), 0);
        check("rst_req_valid", 32'(o_req_valid), 0);
        check("rst_seq_valid", 32'(o_seq_valid), 0);
        check("rst_release", 32'(o_release_valid), 0);
        check("rst_err", 32'(o_err), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(o_job_ready), 1);

        // 1: match with ml>0 advances both heads
        accept_job("t1_acc", 1'b0, 0);
        take_req("t1_req0", 0, 0, 0, 0);
        summary(3, 10, 100, 0, 13, 1'b0, 1'b0);
        pop_seq("t1_seq", 0, 3, 10, 100, 0, 0, 0);
        take_req("t1_req1", 0, 13, 13, 0);

        // 2: ml==0 inside the job only moves match head
        summary(0, 0, 0, 0, 0, 1'b0, 1'b0);
        check("t2_noseq", 32'(o_seq_valid), 0);
        take_req("t2_req", 0, 13, 17, 0);

        // 3: walk match head to 60, then the tail literal run
        summary(0, 5, 7, 0, 27, 1'b0, 1'b0);
        pop_seq("t3_seq5", 0, 0, 5, 7, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            take_req("t3_req", 0, 40, 40 + 4 * k, 0);
            summary(0, 0, 0, 0, 0, 1'b0, 1'b0);
        end
        take_req("t3_tail", 0, 40, 60, 0);
        summary(0, 0, 0, 0, 0, 1'b0, 1'b0);
        check("t3_rel_valid", 32'(o_release_valid), 1);
        check("t3_rel_ctx", 32'(o_release_ctx), 0);
        pop_seq("t3_seq", 0, 24, 0, 0, 1, 0, 0);
        check("t3_rel_pulse", 32'(o_release_valid), 0);
        check("t3_job_ready", 32'(o_job_ready), 1);
        check("t3_no_req", 32'(o_req_valid), 0);

        // 4: move_to_next_job with overlap, then reuse ctx0
        accept_job("t4_acc", 1'b1, 0);
        take_req("t4_req", 0, 0, 0, 1);
        summary(7, 9, 33, 5, 0, 1'b1, 1'b1);
        check("t4_rel_valid", 32'(o_release_valid), 1);
        check("t4_rel_ctx", 32'(o_release_ctx), 0);
        pop_seq("t4_seq", 0, 7, 9, 33, 1, 5, 1);
        check("t4_rel_pulse", 32'(o_release_valid), 0);
        accept_job("t4_reuse", 1'b0, 0);

        // 5: output credits stall issue until a pop
        accept_job("t5_acc1", 1'b0, 1);
        accept_job("t5_acc2", 1'b0, 2);
        accept_job("t5_acc3", 1'b0, 3);
        check("t5_no_free", 32'(o_job_ready), 0);
        take_req("t5_r0", 0, 0, 0, 0);
        take_req("t5_r1", 1, 0, 0, 0);
        take_req("t5_r2", 2, 0, 0, 0);
        take_req("t5_r3", 3, 0, 0, 0);
        check("t5_inflight_cap", 32'(o_req_valid), 0);
        for (int k = 0; k < 4; k++) summary(k + 1, 4, k, 0, 4, 1'b0, 1'b0);
        repeat (3) begin
            check("t5_credit_stall", 32'(o_req_valid), 0);
            @(negedge clk);
        end
        check("t5_seq_valid", 32'(o_seq_valid), 1);
        pop_seq("t5_pop", 0, 1, 4, 0, 0, 0, 0);
        check("t5_reissue", 32'(o_req_valid), 1);
        take_req("t5_r4", 0, 4, 4, 0);
        check("t5_cap2", 32'(o_req_valid), 0);

        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_req", 32'(o_req_valid), 0);
        check("mid_rst_sh", 32'(o_req_seq_head_ptr), 0);
        check("mid_rst_seq", 32'(o_seq_valid), 0);
        check("mid_rst_ll", 32'(o_seq_ll), 0);
        check("mid_rst_rel", 32'(o_release_valid), 0);
        check("mid_rst_ready", 32'(o_job_ready), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 6: two jobs alternate, then reset and a stray summary
        accept_job("t6_acc0", 1'b0, 0);
        accept_job("t6_acc1", 1'b0, 1);
        take_req("t6_r0", 0, 0, 0, 0);
        take_req("t6_r1", 1, 0, 0, 0);
        summary(0, 0, 0, 0, 0, 1'b0, 1'b0);
        summary(0, 0, 0, 0, 0, 1'b0, 1'b0);
        take_req("t6_r2", 0, 0, 4, 0);
        take_req("t6_r3", 1, 0, 4, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_req", 32'(o_req_valid), 0);
        check("t6_rst_ready", 32'(o_job_ready), 0);
        check("t6_rst_err", 32'(o_err), 0);
        rst_n = 1'b1;
        @(negedge clk);
        summary(0, 6, 0, 0, 2, 1'b0, 1'b0);
        check("t6_err", 32'(o_err), 1);
        check("t6_stray_seq", 32'(o_seq_valid), 0);
        check("t6_ready", 32'(o_job_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
